// File: rtl/scan_mux.sv
// N-channel, WIDTH-bit multiplexer with registered output, manual select and a
// dwell-timed auto-scan sequencer. Define SCAN_MUX_CH_MASK_EN to add the ch_mask port.
module scan_mux #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int DWELL = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N*WIDTH-1:0]     in_data,
    input  logic [$clog2(N)-1:0]   sel,
    input  logic                   mode,
    input  logic                   hold,
`ifdef SCAN_MUX_CH_MASK_EN
    input  logic [N-1:0]           ch_mask,
`endif
    output logic [WIDTH-1:0]       y,
    output logic [$clog2(N)-1:0]   cur_sel,
    output logic                   valid,
    output logic                   wrap
);

    localparam int SEL_W = $clog2(N);
    localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {IDLE, MANUAL, SCAN, HOLD} state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    cur_sel_q, cur_sel_d;
    logic [DW_W-1:0]     dwell_q, dwell_d;
    logic [WIDTH-1:0]    y_q, y_d;
    logic                valid_q, valid_d;
    logic                wrap_q, wrap_d;

    logic [N-1:0]        ch_en;
    logic                any_en;
    logic                manual_ok;
    logic                step;
    logic [SEL_W-1:0]    nxt_sel;

`ifdef SCAN_MUX_CH_MASK_EN
    assign ch_en = ch_mask;
`else
    assign ch_en = '1;
`endif

    assign any_en    = |ch_en;
    assign manual_ok = (int'(sel) < N) && ch_en[sel];

    // Next enabled channel above cur in ascending order, wrapping; cur itself if none.
    function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] cur,
                                                 input logic [N-1:0]     en);
        int idx;
        next_ch = cur;
        for (int off = N; off >= 1; off--) begin
            idx = (int'(cur) + off) % N;
            if (en[idx]) next_ch = SEL_W'(idx);
        end
    endfunction

    assign nxt_sel = next_ch(cur_sel_q, ch_en);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d   = state_q;
        cur_sel_d = cur_sel_q;
        dwell_d   = dwell_q;
        wrap_d    = 1'b0;
        step      = 1'b0;
        y_d       = in_data[cur_sel_q*WIDTH +: WIDTH];

        unique case (state_q)
            IDLE: begin
                state_d = mode ? SCAN : MANUAL;
                dwell_d = '0;
            end
            MANUAL: begin
                dwell_d = '0;
                if (mode)           state_d   = SCAN;
                else if (manual_ok) cur_sel_d = sel;
            end
            SCAN, HOLD: begin
                // Leaving for manual wins over hold and over a pending dwell expiry.
                if (!mode) begin
                    state_d = MANUAL;
                    dwell_d = '0;
                    if (manual_ok) cur_sel_d = sel;
                end else if (hold) begin
                    state_d = HOLD;
                end else begin
                    state_d = SCAN;
                    step    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (step) begin
            if (dwell_q == DW_W'(DWELL - 1)) begin
                dwell_d   = '0;
                cur_sel_d = nxt_sel;
                wrap_d    = any_en && (nxt_sel <= cur_sel_q);
            end else begin
                dwell_d = dwell_q + DW_W'(1);
            end
        end

        // y shows the old channel for the one cycle after cur_sel moves.
        valid_d = (state_d != IDLE) && (cur_sel_d == cur_sel_q) && any_en;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q   <= IDLE;
            cur_sel_q <= '0;
            dwell_q   <= '0;
            y_q       <= '0;
            valid_q   <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_sel_q <= cur_sel_d;
            dwell_q   <= dwell_d;
            y_q       <= y_d;
            valid_q   <= valid_d;
            wrap_q    <= wrap_d;
        end
    end

    assign y       = y_q;
    assign cur_sel = cur_sel_q;
    assign valid   = valid_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_scan_mux.sv
// Directed self-checking bench for scan_mux (N=4, WIDTH=8, DWELL=4).
// Build with SCAN_MUX_CH_MASK_EN defined to also exercise the channel mask.
module tb_scan_mux;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic [1:0]  sel;
    logic        mode;
    logic        hold;
    logic [3:0]  ch_mask;
    logic [7:0]  y;
    logic [1:0]  cur_sel;
    logic        valid;
    logic        wrap;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_data [4];

    scan_mux #(.N(4), .WIDTH(8), .DWELL(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .in_data (in_data),
        .sel     (sel),
        .mode    (mode),
        .hold    (hold),
`ifdef SCAN_MUX_CH_MASK_EN
        .ch_mask (ch_mask),
`endif
        .y       (y),
        .cur_sel (cur_sel),
        .valid   (valid),
        .wrap    (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [1:0] e_sel, input logic [7:0] e_y,
                             input logic e_valid, input logic e_wrap);
        check({tag, ".cur_sel"}, 32'(cur_sel), 32'(e_sel));
        check({tag, ".y"},       32'(y),       32'(e_y));
        check({tag, ".valid"},   32'(valid),   32'(e_valid));
        check({tag, ".wrap"},    32'(wrap),    32'(e_wrap));
    endtask

    initial begin
        exp_data = '{8'h11, 8'h22, 8'h33, 8'h44};
        in_data  = 32'h4433_2211;
        rst      = 1'b1;
        mode     = 1'b1;
        sel      = 2'd0;
        hold     = 1'b0;
        ch_mask  = 4'b1111;

        // Reset held for two cycles.
        step();
        step();
        check_out("reset", 2'd0, 8'h00, 1'b0, 1'b0);

        // Release: IDLE -> SCAN, y picks up channel 0.
        rst = 1'b0;
        step();
        check_out("release", 2'd0, 8'h11, 1'b1, 1'b0);

        // Manual select of channel 2, then channel 1.
        mode = 1'b0;
        sel  = 2'd2;
        step();
        check_out("man_sel2_a", 2'd2, 8'h11, 1'b0, 1'b0);
        step();
        check_out("man_sel2_b", 2'd2, 8'h33, 1'b1, 1'b0);
        sel = 2'd1;
        step();
        check_out("man_sel1_a", 2'd1, 8'h33, 1'b0, 1'b0);
        step();
        check_out("man_sel1_b", 2'd1, 8'h22, 1'b1, 1'b0);

        // Return to channel 0 before scanning.
        sel = 2'd0;
        step();
        step();
        check_out("man_sel0", 2'd0, 8'h11, 1'b1, 1'b0);

        // MANUAL -> SCAN keeps cur_sel and starts the dwell count at 0.
        mode = 1'b1;
        step();
        check_out("scan_entry", 2'd0, 8'h11, 1'b1, 1'b0);

        // Full scan 0 -> 1 -> 2 -> 3 -> 0, four cycles per channel.
        for (int k = 1; k <= 4; k++) begin
            step();
            check_out($sformatf("scan%0d_settled", k), 2'(k - 1), exp_data[k - 1], 1'b1, 1'b0);
            step();
            step();
            check($sformatf("scan%0d_dwell.cur_sel", k), 32'(cur_sel), 32'(k - 1));
            step();
            check_out($sformatf("scan%0d_step", k), 2'(k % 4), exp_data[k - 1], 1'b0, (k == 4));
        end

        // Move to channel 1 at dwell count 2.
        step();
        check_out("wrap_cleared", 2'd0, 8'h11, 1'b1, 1'b0);
        step();
        step();
        step();
        check_out("to_ch1", 2'd1, 8'h11, 1'b0, 1'b0);
        step();
        step();

        // Hold for five cycles at dwell count 2 on channel 1.
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_out($sformatf("hold%0d", i), 2'd1, 8'h22, 1'b1, 1'b0);
        end
        hold = 1'b0;
        step();
        check_out("resume_a", 2'd1, 8'h22, 1'b1, 1'b0);
        step();
        check_out("resume_b", 2'd2, 8'h22, 1'b0, 1'b0);

        // Run to channel 3 at dwell count 3, then reset right before the wrap.
        step();
        step();
        step();
        step();
        check_out("to_ch3", 2'd3, 8'h33, 1'b0, 1'b0);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        check_out("mid_reset", 2'd0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        check_out("post_reset", 2'd0, 8'h11, 1'b1, 1'b0);

`ifdef SCAN_MUX_CH_MASK_EN
        // Only channels 1 and 3 enabled: 0 -> 1 -> 3 -> 1, wrap on 3 -> 1.
        ch_mask = 4'b1010;
        repeat (4) step();
        check_out("mask_to1", 2'd1, 8'h11, 1'b0, 1'b0);
        repeat (4) step();
        check_out("mask_to3", 2'd3, 8'h22, 1'b0, 1'b0);
        repeat (4) step();
        check_out("mask_wrap", 2'd1, 8'h44, 1'b0, 1'b1);

        // Empty mask freezes cur_sel and drops valid.
        ch_mask = 4'b0000;
        step();
        check_out("mask_zero_a", 2'd1, 8'h22, 1'b0, 1'b0);
        repeat (4) step();
        check_out("mask_zero_b", 2'd1, 8'h22, 1'b0, 1'b0);
        ch_mask = 4'b1111;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scan_mux.md
Name: scan_mux

Overview:
- Parametrised successor to the team's 2:1 MUX: N-channel, WIDTH-bit multiplexer with a registered output.
- Two select modes: manual (external select) and auto-scan, where an internal sequencer steps through channels every DWELL cycles.
- Sits between parallel data sources and a single downstream consumer, such as a display or serial driver. Provides valid and wrap status.

Parameters:
- N, 4, number of input channels (N >= 2).
- WIDTH, 8, bits per channel.
- DWELL, 4, cycles spent on each channel in auto-scan (DWELL >= 1).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_data  in  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- sel  in  clog2(N)  manual channel select.
- mode  in  1  0 = manual, 1 = auto-scan.
- hold  in  1  freezes the auto-scan sequencer.
- y  out  WIDTH  registered selected data.
- cur_sel  out  clog2(N)  currently selected channel (registered).
- valid  out  1  y corresponds to cur_sel.
- wrap  out  1  one-cycle pulse when the scan wraps from N-1 to 0.

Behaviour:
- Reset: the interface is one clock and a synchronous active-high reset, named clk and rst.
  - rst=1 at a rising edge forces y=0, cur_sel=0, dwell count=0, valid=0, wrap=0, state=IDLE.
  - Reset mid-scan aborts immediately; there is no partial-dwell carry-over.
- States: IDLE, MANUAL, SCAN, HOLD.
  - IDLE -> MANUAL (mode=0) or SCAN (mode=1) on the first cycle after rst deasserts.
  - MANUAL <-> SCAN follows mode every cycle. Any entry to SCAN clears the dwell count and starts from the present cur_sel.
  - SCAN -> HOLD when hold=1. HOLD -> SCAN when hold=0, resuming the dwell count where it stopped. HOLD -> MANUAL when mode=0.
- MANUAL:
  - cur_sel <= sel each cycle.
  - sel >= N (non-power-of-2 N) is ignored and cur_sel holds.
  - The dwell count is held at 0.
- SCAN:
  - The dwell count increments 0..DWELL-1.
  - At DWELL-1 the count returns to 0 and cur_sel <= (cur_sel==N-1) ? 0 : cur_sel+1.
  - wrap=1 for exactly the cycle after cur_sel goes N-1 -> 0; otherwise wrap=0.
  - DWELL=1 advances the channel every cycle.
- HOLD: the dwell count and cur_sel are frozen. wrap=0.
- Data path:
  - y <= in_data slice indexed by the registered cur_sel, every cycle, in every state except reset.
  - y therefore lags a cur_sel change by 1 cycle.
  - Live in_data changes on an unchanged channel appear on y after 1 cycle.
- valid:
  - 0 in IDLE.
  - 0 for exactly one cycle following any change of cur_sel (y still shows the old channel).
  - 1 otherwise.
- Simultaneous events:
  - rst has priority over everything.
  - mode change has priority over hold.
  - A mode 1->0 transition on the dwell-expiry cycle takes sel and does not advance the scan.
  - hold=1 on the expiry cycle blocks the advance.

Optional Feature:
- Macro: SCAN_MUX_CH_MASK_EN.
- When defined:
  - Adds input port ch_mask, N bits, where bit k=1 enables channel k.
  - SCAN advances to the next enabled channel in ascending order with wrap-around. wrap pulses when that order passes N-1 -> lowest enabled.
  - MANUAL select of a disabled channel is ignored and cur_sel holds.
  - If cur_sel becomes disabled, cur_sel moves to the next enabled channel at the next dwell expiry.
  - All-zero mask: cur_sel holds, valid=0, wrap=0.
- When not defined: port absent; all channels are always enabled.

Test Plan:
All scenarios use N=4, WIDTH=8, DWELL=4, in_data = {8'h44, 8'h33, 8'h22, 8'h11}.
1. Reset: drive rst=1 for 2 cycles with mode=1 -> y=0, cur_sel=0, valid=0, wrap=0. Release -> y=8'h11 one cycle later, valid=1.
2. Manual: mode=0, sel=2 -> cur_sel=2 next cycle with valid=0, then y=8'h33 with valid=1. Then sel=1 -> y=8'h22 two cycles after sel change.
3. Auto-scan: mode=1 from cur_sel=0 -> cur_sel steps 0,1,2,3,0 every 4 cycles. wrap=1 for a single cycle at 3->0. valid is low one cycle after each step.
4. Hold: assert hold at dwell count 2 on channel 1 for 5 cycles -> cur_sel stays 1, y=8'h22. After release, the advance to 2 occurs 2 cycles later.
5. Reset mid-scan: rst=1 on channel 3 at dwell count 3 -> next cycle cur_sel=0, y=0, no wrap pulse.
6. With SCAN_MUX_CH_MASK_EN, ch_mask=4'b1010, mode=1 -> cur_sel cycles 1,3,1, with wrap on 3->1. ch_mask=0 -> cur_sel frozen, valid=0.
